// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and helpers for the parity link
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int unsigned MAX_DATA_W = 16;

  // Parity bit the transmitter appends so that data plus parity meets the mode.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input bit odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// rtl/parity_accum.sv - 1-bit XOR accumulator with clear and enable
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc
);

  // Clear wins over enable so a new frame always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - receive-side deserialiser with parity and framing check
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 3,
  parameter bit          ODD_PARITY = PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_next;
  logic              perr_q;
  logic              acc;
  logic              acc_clr;
  logic              acc_en;
  logic              last_bit;

  assign last_bit = (cnt_q == LAST_BIT);
  assign busy     = (state_q != IDLE);

  // New bits enter at the MSB so the first received bit ends up in bit 0.
  generate
    if (DATA_W == 1) begin : g_shift_single
      assign shreg_next = sin;
    end else begin : g_shift_multi
      assign shreg_next = {sin, shreg_q[DATA_W-1:1]};
    end
  endgenerate

  parity_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (sin),
    .acc   (acc)
  );

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and accumulator control; nothing moves without a sample strobe.
  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            acc_clr = 1'b1;
          end
        end
        DATA: begin
          acc_en = 1'b1;
          if (last_bit) begin
            state_d = PARITY;
          end
        end
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: bit count, shifting, error latching and the one-cycle result pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!sin) begin
              cnt_q <= '0;
            end
          end
          DATA: begin
            shreg_q <= shreg_next;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
          PARITY: begin
            perr_q <= (sin != (acc ^ ODD_PARITY));
          end
          STOP: begin
            data_out   <= shreg_q;
            parity_err <= perr_q;
            frame_err  <= ~sin;
            data_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - scoreboard bench for serial_parity_checker
module tb_serial_parity_checker;

  typedef struct {
    logic [2:0] data;
    bit         perr;
    bit         ferr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       sin;
  logic [2:0] do_e, do_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q_even[$];
  exp_t q_odd[$];
  logic [2:0] last_data [2];
  bit         prev_valid [2];

  serial_parity_checker #(.DATA_W(3), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
    .data_out(do_e), .data_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e), .busy(busy_e)
  );

  serial_parity_checker #(.DATA_W(3), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
    .data_out(do_o), .data_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_out(input int idx, input logic v, input logic [2:0] d,
                           input logic pe, input logic fe);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (v === 1'b1) begin
      if (idx == 0 && q_even.size() > 0) begin
        e = q_even.pop_front();
        have = 1'b1;
      end else if (idx == 1 && q_odd.size() > 0) begin
        e = q_odd.pop_front();
        have = 1'b1;
      end
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL spurious_valid dut%0d: got data_valid=1 at cycle %0d, expected no frame", idx, cyc);
      end else begin
        checks++;
        if (d !== e.data || pe !== e.perr || fe !== e.ferr || cyc != e.cyc) begin
          errors++;
          $display("FAIL frame dut%0d: got data=%b perr=%b ferr=%b cyc=%0d, expected data=%b perr=%b ferr=%b cyc=%0d",
                   idx, d, pe, fe, cyc, e.data, e.perr, e.ferr, e.cyc);
        end
        last_data[idx] = e.data;
      end
      checks++;
      if (prev_valid[idx]) begin
        errors++;
        $display("FAIL pulse_width dut%0d: got data_valid high two cycles, expected one", idx);
      end
    end else begin
      checks++;
      if (v !== 1'b0 || pe !== 1'b0 || fe !== 1'b0 || d !== last_data[idx]) begin
        errors++;
        $display("FAIL idle_outputs dut%0d: got valid=%b perr=%b ferr=%b data=%b, expected 0 0 0 data=%b",
                 idx, v, pe, fe, d, last_data[idx]);
      end
    end
    prev_valid[idx] = (v === 1'b1);
  endtask

  always @(negedge clk) begin
    check_out(0, dv_e, do_e, pe_e, fe_e);
    check_out(1, dv_o, do_o, pe_o, fe_o);
  end

  task automatic check_busy(input bit exp, input string tag);
    checks++;
    if (busy_e !== exp) begin
      errors++;
      $display("FAIL busy_%s dut0: got %b, expected %b", tag, busy_e, exp);
    end
    checks++;
    if (busy_o !== exp) begin
      errors++;
      $display("FAIL busy_%s dut1: got %b, expected %b", tag, busy_o, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({do_e, dv_e, pe_e, fe_e, busy_e} !== 7'd0) begin
      errors++;
      $display("FAIL reset_%s dut0: got data=%b valid=%b perr=%b ferr=%b busy=%b, expected all 0",
               tag, do_e, dv_e, pe_e, fe_e, busy_e);
    end
    checks++;
    if ({do_o, dv_o, pe_o, fe_o, busy_o} !== 7'd0) begin
      errors++;
      $display("FAIL reset_%s dut1: got data=%b valid=%b perr=%b ferr=%b busy=%b, expected all 0",
               tag, do_o, dv_o, pe_o, fe_o, busy_o);
    end
  endtask

  // One enabled sample preceded by 'gap' disabled cycles carrying random line noise.
  task automatic sample(input bit v, input int gap, input bit exp_busy_gap);
    for (int g = 0; g < gap; g++) begin
      bit_en = 1'b0;
      sin    = 1'($urandom);
      @(posedge clk);
      #1;
      check_busy(exp_busy_gap, "gap");
    end
    bit_en = 1'b1;
    sin    = v;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    for (int k = 0; k < n; k++) begin
      sample(1'b1, 0, 1'b0);
      check_busy(1'b0, "idle");
    end
  endtask

  task automatic send_frame(input logic [2:0] d, input bit pbit, input bit stop, input int gap);
    exp_t e;
    int   ones;
    sample(1'b0, gap, 1'b0);
    check_busy(1'b1, "start");
    for (int i = 0; i < 3; i++) begin
      sample(d[i], gap, 1'b1);
      check_busy(1'b1, "data");
    end
    sample(pbit, gap, 1'b1);
    check_busy(1'b1, "parity");
    sample(stop, gap, 1'b1);
    ones   = $countones(d) + int'(pbit);
    e.data = d;
    e.ferr = !stop;
    e.cyc  = cyc;
    e.perr = (ones % 2) != 0;
    q_even.push_back(e);
    e.perr = (ones % 2) != 1;
    q_odd.push_back(e);
    check_busy(1'b0, "after_stop");
  endtask

  initial begin
    logic [2:0] d;
    bit         pb;
    last_data[0]  = 3'd0;
    last_data[1]  = 3'd0;
    prev_valid[0] = 1'b0;
    prev_valid[1] = 1'b0;
    rst_n  = 1'b1;
    bit_en = 1'b0;
    sin    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("initial");
    rst_n = 1'b1;

    send_frame(3'b101, 1'b0, 1'b1, 0);
    send_frame(3'b011, 1'b1, 1'b1, 0);
    send_frame(3'b110, 1'b0, 1'b0, 0);
    send_frame(3'b001, 1'b1, 1'b1, 0);
    idle_bits(2);
    send_frame(3'b111, 1'b0, 1'b1, 3);

    for (int v = 0; v < 8; v++) begin
      d  = 3'(v);
      pb = ($countones(d) % 2) != 0;
      send_frame(d, pb, 1'b1, 0);
      send_frame(d, !pb, 1'b1, 1);
    end

    sample(1'b0, 0, 1'b0);
    sample(1'b1, 0, 1'b1);
    sample(1'b0, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_frame");
    last_data[0] = 3'd0;
    last_data[1] = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(3'b010, 1'b1, 1'b1, 0);

    for (int n = 0; n < 150; n++) begin
      idle_bits(int'($urandom_range(0, 1)));
      send_frame(3'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), int'($urandom_range(0, 2)));
    end

    idle_bits(3);
    checks++;
    if (q_even.size() != 0 || q_odd.size() != 0) begin
      errors++;
      $display("FAIL missing_frames: got %0d/%0d unreported frames, expected 0/0", q_even.size(), q_odd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Receive end of the team's 3-bit parity link; the existing parity generator produces the even/odd parity bit at the transmit end.
- Deserialises one frame (start bit, DATA_W data bits LSB-first, parity bit, stop bit) sampled on a bit-enable strobe.
- Recomputes parity and reports recovered data with parity and framing error flags.
- Sits between the serial line and the downstream register or consumer.

Parameters:
- DATA_W, 3, number of data bits per frame (matches the a/b/c generator width); legal range 1..16.
- ODD_PARITY, 0, 0 = even parity expected (total ones incl. parity bit even); 1 = odd parity expected.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bit_en  input  1  sample strobe; FSM and datapath advance only on cycles with bit_en=1.
- sin  input  1  serial line; idle level 1.
- data_out  output  DATA_W  last received data word; bit 0 = first data bit received.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch for the completed frame; qualified by data_valid, 0 otherwise.
- frame_err  output  1  stop bit sampled as 0; qualified by data_valid, 0 otherwise.
- busy  output  1  1 while state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0.
  - Bit counter, shift register and parity accumulator cleared.
  - A reset mid-frame discards the partial frame; no data_valid is issued for it.
- All registers update on the clk rising edge. Cycles with bit_en=0 hold all state; data_valid is still cleared on those cycles.
- FSM (transitions only on bit_en=1):
  - IDLE:
    - sin=1: stay in IDLE.
    - sin=0: start bit. Go to DATA; counter=0; accumulator=0.
  - DATA:
    - Shift sin into the shift register MSB end (right shift), so the word is LSB-first aligned after DATA_W bits.
    - accumulator ^= sin; counter++.
    - On the DATA_W-th bit, go to PARITY.
  - PARITY:
    - Expected parity bit = accumulator ^ ODD_PARITY.
    - Latch perr = (sin != expected). Go to STOP.
  - STOP:
    - Latch ferr = ~sin.
    - data_out <= shift register; parity_err <= perr; frame_err <= ferr; data_valid <= 1 for exactly one clock. All appear the cycle after the STOP-sample edge.
    - Return to IDLE.
- After a framing error, the FSM returns to IDLE and does not hunt for resync. A following bit_en with sin=0 starts a new frame.
- Latency:
  - Frame occupies DATA_W+3 enabled samples.
  - data_valid asserts 1 clk after the stop sample.
  - data_out holds until the next completed frame.
- bit_en asserted every cycle is legal: back-to-back frames with no idle bit, start sample directly after the stop sample.
- The counter width is $clog2(DATA_W+1). It never wraps within a frame.
- The block never blocks (no backpressure). The consumer must take data_valid in the pulse cycle.

Decomposition:
- Shared package parity_pkg:
  - State enum (IDLE, DATA, PARITY, STOP), 2 bits.
  - Constants PAR_EVEN=0, PAR_ODD=1 (reused by the generator side).
  - Function calc_parity(data, odd) returning the expected parity bit.
- One natural sub-module: parity_accum (1-bit XOR accumulator with clear/enable). Otherwise a single module with FSM plus datapath.

Test Plan:
- Good frame, even mode, bit_en=1 every cycle: sin=0,1,0,1,0,1 (data 3'b101, parity 0) -> data_out=3'b101, data_valid one cycle, parity_err=0, frame_err=0.
- Parity error, even mode: sin=0,1,1,0,1,1 (data 3'b011, parity 1, expected 0) -> data_out=3'b011, parity_err=1, frame_err=0 with data_valid.
- Framing error: data 3'b110, correct parity 0, stop sin=0 -> frame_err=1, parity_err=0. Then a new good frame with data 3'b001 -> data_out=3'b001, no errors.
- ODD_PARITY=1, bit_en every 4th cycle: data 3'b111, parity bit 0 -> no errors. busy=1 across all 6 enabled samples. Nothing changes on bit_en=0 cycles.
- Sweep all 8 data values in both modes, with parity driven by a reference calc_parity -> zero errors. Inverted parity bit -> parity_err=1 for every word.
- Reset mid-frame: drop rst_n after 2 data bits -> outputs 0, busy=0 immediately (async). A following full frame with data 3'b010 decodes correctly; no spurious data_valid.
